// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: load/store type codes, LSU FSM states and access-size decode.
package load_store_unit_pkg;
    localparam logic [4:0] LS_TYPE_LW   = 5'd0;
    localparam logic [4:0] LS_TYPE_LH   = 5'd1;
    localparam logic [4:0] LS_TYPE_LHU  = 5'd2;
    localparam logic [4:0] LS_TYPE_LB   = 5'd3;
    localparam logic [4:0] LS_TYPE_LBU  = 5'd4;
    localparam logic [4:0] LS_TYPE_SW   = 5'd5;
    localparam logic [4:0] LS_TYPE_SH   = 5'd6;
    localparam logic [4:0] LS_TYPE_SB   = 5'd7;
    localparam logic [4:0] LS_TYPE_NONE = 5'd8;

    typedef enum logic [2:0] {IDLE, ACC0, RSP0, ACC1, RSP1, DONE} lsu_state_e;

    // Lane mask of the access at offset 0; zero for NONE and invalid codes.
    function automatic logic [3:0] size_mask(input logic [4:0] ls_type);
        return (ls_type == LS_TYPE_LW || ls_type == LS_TYPE_SW) ? 4'b1111 :
               (ls_type == LS_TYPE_LH || ls_type == LS_TYPE_LHU || ls_type == LS_TYPE_SH) ? 4'b0011 :
               (ls_type == LS_TYPE_LB || ls_type == LS_TYPE_LBU || ls_type == LS_TYPE_SB) ? 4'b0001 :
               4'b0000;
    endfunction

    function automatic logic is_store(input logic [4:0] ls_type);
        return ls_type >= LS_TYPE_SW && ls_type <= LS_TYPE_SB;
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store lane shift/byte-enable generation and load realign/extend.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [4:0]  ls_type,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    output logic [7:0]  mask8,
    output logic [63:0] data64,
    output logic [31:0] load_data
);
    logic [3:0]  mask;
    logic [31:0] store_masked;
    logic [63:0] shifted;

    always_comb begin
        mask         = size_mask(ls_type);
        // Clear bytes beyond the access size so unused write lanes stay zero.
        store_masked = store_data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        mask8        = {4'b0000, mask} << offset;
        data64       = {32'b0, store_masked} << {offset, 3'b000};
        shifted      = {hi_word, lo_word} >> {offset, 3'b000};
        load_data    = (ls_type == LS_TYPE_LW)  ? shifted[31:0] :
                       (ls_type == LS_TYPE_LH)  ? {{16{shifted[15]}}, shifted[15:0]} :
                       (ls_type == LS_TYPE_LHU) ? {16'b0, shifted[15:0]} :
                       (ls_type == LS_TYPE_LB)  ? {{24{shifted[7]}}, shifted[7:0]} :
                       (ls_type == LS_TYPE_LBU) ? {24'b0, shifted[7:0]} :
                       32'b0;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns byte/half/word loads and stores into word-aligned memory
// transactions, splitting accesses that cross a word boundary.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int LS_TYPE_WIDTH = 5
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Request_Valid,
    output logic                     o_Request_Ready,
    input  logic [LS_TYPE_WIDTH-1:0] i_Load_Store_Type,
    input  logic [XLEN-1:0]          i_Addr,
    input  logic [XLEN-1:0]          i_Store_Data,
    output logic                     o_Result_Valid,
    output logic [XLEN-1:0]          o_Result_Data,
    output logic                     o_Mem_Valid,
    input  logic                     i_Mem_Ready,
    output logic [XLEN-1:0]          o_Mem_Addr,
    output logic                     o_Mem_Write,
    output logic [3:0]               o_Mem_Byte_Enable,
    output logic [XLEN-1:0]          o_Mem_Write_Data,
    input  logic                     i_Mem_Read_Valid,
    input  logic [XLEN-1:0]          i_Mem_Read_Data
);
    lsu_state_e               state, state_next;
    logic [LS_TYPE_WIDTH-1:0] type_q;
    logic [XLEN-1:0]          addr_q, data_q, lo_q, hi_q, load_data, word_addr;
    logic [7:0]               mask8;
    logic [63:0]              data64;
    logic                     accept, split, hi_phase;

    lsu_lane_align u_lane_align (
        .ls_type   (type_q),
        .offset    (addr_q[1:0]),
        .store_data(data_q),
        .lo_word   (lo_q),
        .hi_word   (hi_q),
        .mask8     (mask8),
        .data64    (data64),
        .load_data (load_data)
    );

    assign accept    = i_Request_Valid && o_Request_Ready;
    assign split     = |mask8[7:4];
    assign hi_phase  = state == ACC1;
    // High word wraps naturally at the top of the address space.
    assign word_addr = {addr_q[XLEN-1:2], 2'b00} + (hi_phase ? XLEN'(4) : XLEN'(0));

    always_comb begin
        o_Request_Ready   = state == IDLE;
        o_Mem_Valid       = state == ACC0 || state == ACC1;
        o_Mem_Addr        = o_Mem_Valid ? word_addr : '0;
        o_Mem_Write       = o_Mem_Valid && is_store(type_q);
        o_Mem_Byte_Enable = !o_Mem_Valid ? 4'b0000 : hi_phase ? mask8[7:4] : mask8[3:0];
        o_Mem_Write_Data  = !o_Mem_Write ? '0 : hi_phase ? data64[63:32] : data64[31:0];
        o_Result_Valid    = state == DONE;
        o_Result_Data     = o_Result_Valid ? load_data : '0;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (i_Load_Store_Type <= LS_TYPE_SB) ? ACC0 : DONE;
            ACC0: if (i_Mem_Ready) state_next = !is_store(type_q) ? RSP0 : split ? ACC1 : DONE;
            RSP0: if (i_Mem_Read_Valid) state_next = split ? ACC1 : DONE;
            ACC1: if (i_Mem_Ready) state_next = !is_store(type_q) ? RSP1 : DONE;
            RSP1: if (i_Mem_Read_Valid) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) state <= IDLE;
        else state <= state_next;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            type_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
        end else begin
            if (accept) begin
                type_q <= i_Load_Store_Type;
                addr_q <= i_Addr;
                data_q <= i_Store_Data;
            end
            if (state == RSP0 && i_Mem_Read_Valid) lo_q <= i_Mem_Read_Data;
            if (state == RSP1 && i_Mem_Read_Valid) hi_q <= i_Mem_Read_Data;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized accesses checked against a byte-level
// memory model that derives expected transactions and load values byte by byte.
module tb_load_store_unit;
    logic        clk = 0, rst = 0;
    logic        req_valid, req_ready, res_valid, mem_valid, mem_ready, mem_write, mem_rvalid;
    logic [4:0]  ls_type;
    logic [31:0] addr, sdata, res_data, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wd;
    } txn_t;

    txn_t        exp_q[$], got_q[$];
    logic [7:0]  mem [logic [31:0]];
    int          tests = 0, fails = 0, cyc = 0, pend_cnt = 0, spur_mode = 0;
    bit          rand_mode = 0, stall = 0, hold_resp = 0, pend = 0;
    logic [31:0] pend_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    load_store_unit dut (
        .i_Clock          (clk),
        .i_Reset          (rst),
        .i_Request_Valid  (req_valid),
        .o_Request_Ready  (req_ready),
        .i_Load_Store_Type(ls_type),
        .i_Addr           (addr),
        .i_Store_Data     (sdata),
        .o_Result_Valid   (res_valid),
        .o_Result_Data    (res_data),
        .o_Mem_Valid      (mem_valid),
        .i_Mem_Ready      (mem_ready),
        .o_Mem_Addr       (mem_addr),
        .o_Mem_Write      (mem_write),
        .o_Mem_Byte_Enable(mem_be),
        .o_Mem_Write_Data (mem_wdata),
        .i_Mem_Read_Valid (mem_rvalid),
        .i_Mem_Read_Data  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a[7:0] ^ a[15:8]) + 8'h5a;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] wa);
        return {byte_at(wa + 32'd3), byte_at(wa + 32'd2), byte_at(wa + 32'd1), byte_at(wa)};
    endfunction

    task automatic poke(input logic [31:0] wa, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[wa + 32'(i)] = w[8*i +: 8];
    endtask

    // Walk the accessed bytes one at a time; each byte lands in the word that holds it.
    function automatic void model(input logic [4:0] t, input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] res, output int lat);
        logic [31:0] wa [2], wd [2];
        logic [3:0]  be [2];
        logic [31:0] v, ba;
        int          n, nw, k, ln;
        bit          st;
        n  = (t == 0 || t == 5) ? 4 : (t == 1 || t == 2 || t == 6) ? 2 : (t == 3 || t == 4 || t == 7) ? 1 : 0;
        st = t >= 5 && t <= 7;
        v  = 0;
        nw = 0;
        for (int j = 0; j < 2; j++) begin
            wa[j] = 0; wd[j] = 0; be[j] = 0;
        end
        for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            k  = int'(((ba & ~32'h3) - (a & ~32'h3)) >> 2);
            ln = int'(ba[1:0]);
            wa[k]     = ba & ~32'h3;
            be[k][ln] = 1'b1;
            if (st) wd[k][8*ln +: 8] = d[8*i +: 8];
            v[8*i +: 8] = byte_at(ba);
            if (k + 1 > nw) nw = k + 1;
        end
        exp_q.delete();
        for (int j = 0; j < nw; j++) exp_q.push_back(txn_t'{wa[j], st, be[j], wd[j]});
        res = (st || n == 0) ? 32'h0 : (t == 1) ? {{16{v[15]}}, v[15:0]} : (t == 3) ? {{24{v[7]}}, v[7:0]} : v;
        lat = (n == 0) ? 1 : st ? 2 + (nw - 1) : 3 + 2 * (nw - 1);
    endfunction

    // Memory: optional stalls, read data 1..3 cycles after accept, optional stray read-valids.
    initial begin
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        forever begin
            @(negedge clk);
            mem_rvalid = 0;
            mem_rdata  = 0;
            if (pend && !hold_resp) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    pend = 0; mem_rvalid = 1; mem_rdata = pend_data;
                end
            end else if (!pend && (spur_mode == 2 || (spur_mode == 1 && $urandom_range(0, 3) == 0))) begin
                mem_rvalid = 1; mem_rdata = $urandom;
            end
            mem_ready = rand_mode ? ($urandom_range(0, 2) != 0) : !stall;
            if (mem_valid && mem_ready) begin
                got_q.push_back(txn_t'{mem_addr, mem_write, mem_be, mem_wdata});
                if (mem_write) begin
                    for (int i = 0; i < 4; i++) if (mem_be[i]) mem[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
                end else begin
                    pend = 1;
                    pend_cnt = rand_mode ? int'($urandom_range(1, 3)) : 1;
                    pend_data = word_at(mem_addr);
                end
            end
        end
    end

    task automatic do_op(input logic [4:0] t, input logic [31:0] a, input logic [31:0] d,
                         input int stall_n, input bit chk_lat, output logic [31:0] res);
        logic [31:0] exp_res;
        int          exp_lat, c0, lat;
        bit          seen;
        seen = 0; res = 0; lat = 0;
        model(t, a, d, exp_res, exp_lat);
        got_q.delete();
        stall = stall_n > 0;
        @(negedge clk);
        check("req_ready", 32'(req_ready), 1);
        req_valid = 1; ls_type = t; addr = a; sdata = d; c0 = cyc;
        @(negedge clk);
        req_valid = 0; ls_type = 5'($urandom); addr = $urandom; sdata = $urandom;
        for (int i = 0; i < stall_n; i++) begin
            check("stall_mem_valid", 32'(mem_valid), 1);
            check("stall_addr", mem_addr, exp_q[0].addr);
            check("stall_be", 32'(mem_be), 32'(exp_q[0].be));
            check("stall_wdata", mem_wdata, exp_q[0].wd);
            check("stall_req_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        stall = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (res_valid) begin
                seen = 1; res = res_data; lat = cyc - c0;
            end else @(negedge clk);
        end
        check("res_seen", 32'(seen), 1);
        if (seen) begin
            check("result", res, exp_res);
            if (chk_lat) check("latency", lat, exp_lat);
            @(negedge clk);
            check("pulse_len", 32'(res_valid), 0);
            check("res_idle_zero", res_data, 0);
        end
        check("txn_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check("txn_addr", got_q[i].addr, exp_q[i].addr);
            check("txn_write", 32'(got_q[i].wr), 32'(exp_q[i].wr));
            check("txn_be", 32'(got_q[i].be), 32'(exp_q[i].be));
            if (exp_q[i].wr) check("txn_wdata", got_q[i].wd, exp_q[i].wd);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        logic [31:0] r, a;
        logic [4:0]  t;
        req_valid = 0; ls_type = 0; addr = 0; sdata = 0;
        #1 rst = 1;
        #2;
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_data", res_data, 0);
        check("rst_mem_valid", 32'(mem_valid), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", 32'(mem_be), 0);
        check("rst_mem_write", 32'(mem_write), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        do_op(5, 32'h100, 32'hDEADBEEF, 0, 1, r);
        check("t1_result", r, 0);
        if (got_q.size() > 0) check("t1_wdata", got_q[0].wd, 32'hDEADBEEF);

        poke(32'h100, 32'h80112233);
        do_op(3, 32'h103, $urandom, 0, 1, r);
        check("t2_lb", r, 32'hFFFFFF80);
        do_op(4, 32'h103, $urandom, 0, 1, r);
        check("t2_lbu", r, 32'h00000080);
        do_op(1, 32'h100, $urandom, 0, 1, r);
        check("t2_lh", r, 32'h00002233);

        do_op(6, 32'h103, 32'h0000ABCD, 0, 1, r);
        if (got_q.size() == 2) begin
            check("t3_addr0", got_q[0].addr, 32'h100);
            check("t3_be0", 32'(got_q[0].be), 32'b1000);
            check("t3_data0", got_q[0].wd, 32'hCD000000);
            check("t3_addr1", got_q[1].addr, 32'h104);
            check("t3_be1", 32'(got_q[1].be), 32'b0001);
            check("t3_data1", got_q[1].wd, 32'h000000AB);
        end

        poke(32'h100, 32'h44332211);
        poke(32'h104, 32'h88776655);
        do_op(0, 32'h102, 0, 0, 1, r);
        check("t4_lw_split", r, 32'h66554433);

        do_op(6, 32'hFFFFFFFF, 32'h5A5A1234, 0, 1, r);
        if (got_q.size() == 2) check("wrap_addr", got_q[1].addr, 32'h0);
        do_op(0, 32'hFFFFFFFE, 0, 0, 1, r);
        do_op(8, 32'h104, 32'h12345678, 0, 1, r);
        do_op(5'd20, 32'h104, 32'h12345678, 0, 1, r);

        spur_mode = 2;
        repeat (4) begin
            @(negedge clk);
            check("spur_res_valid", 32'(res_valid), 0);
            check("spur_req_ready", 32'(req_ready), 1);
        end
        spur_mode = 0;
        do_op(5, 32'h200, 32'hCAFEF00D, 3, 0, r);

        hold_resp = 1;
        @(negedge clk);
        req_valid = 1; ls_type = 0; addr = 32'h40;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        check("rsp0_busy", 32'(req_ready), 0);
        #2 rst = 1;
        #1;
        check("rstmid_mem_valid", 32'(mem_valid), 0);
        check("rstmid_req_ready", 32'(req_ready), 1);
        check("rstmid_res_valid", 32'(res_valid), 0);
        check("rstmid_mem_addr", mem_addr, 0);
        @(negedge clk);
        #2 rst = 0;
        hold_resp = 0;
        repeat (5) begin
            @(negedge clk);
            check("late_rsp_res_valid", 32'(res_valid), 0);
            check("late_rsp_req_ready", 32'(req_ready), 1);
        end
        do_op(0, 32'h0, 0, 0, 1, r);

        rand_mode = 1;
        spur_mode = 1;
        repeat (300) begin
            t = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                             : 32'h100 + 32'($urandom_range(0, 63));
            do_op(t, a, $urandom, 0, 0, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
